// File: rtl/btn_pkg.sv
// Shared constants, FSM encoding and direction priority helper for the button conditioner.
package btn_pkg;

   localparam int unsigned NUM_BTN = 5;
   localparam int unsigned DIR_W   = 2;

   localparam int unsigned BTN_START = 0;
   localparam int unsigned BTN_UP    = 1;
   localparam int unsigned BTN_DOWN  = 2;
   localparam int unsigned BTN_LEFT  = 3;
   localparam int unsigned BTN_RIGHT = 4;

   localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
   localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
   localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
   localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      REQ      = 2'b01,
      WAIT_REL = 2'b10
   } move_state_e;

   // Pick one direction from simultaneous rising edges: up > down > left > right.
   // Bit 0 of rise_dir is up, bit 3 is right.
   function automatic logic [DIR_W-1:0] prio_dir(input logic [3:0] rise_dir);
      logic [DIR_W-1:0] dir;
      if (rise_dir[0])      dir = DIR_UP;
      else if (rise_dir[1]) dir = DIR_DOWN;
      else if (rise_dir[2]) dir = DIR_LEFT;
      else                  dir = DIR_RIGHT;
      return dir;
   endfunction

endpackage

// File: rtl/btn_conditioner_debounce_bit.sv
// One button: 2-flop synchroniser followed by a counting debouncer.
module debounce_bit #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o
);

   logic             meta_q;
   logic             sync_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Two-flop synchroniser for the asynchronous board input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= raw_i;
         sync_q <= meta_q;
      end
   end

   // Count consecutive disagreeing samples; flip stable value on the last one.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level_o = stable_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces five board buttons and turns them into a start pulse and one move per press.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic               move_ack,
   output logic [NUM_BTN-1:0] btn_level,
   output logic               start_pulse,
   output logic               move_req,
   output logic [DIR_W-1:0]   move_dir
);

   logic [NUM_BTN-1:0] level_dly_q;
   logic [NUM_BTN-1:0] rise;
   logic               start_pulse_q;
   move_state_e        state_q;
   move_state_e        state_d;
   logic               move_req_q;
   logic               move_req_d;
   logic [DIR_W-1:0]   move_dir_q;
   logic [DIR_W-1:0]   move_dir_d;

   // Per-button synchroniser and debouncer.
   for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_db
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .clk     (clk),
         .rst     (rst),
         .raw_i   (btn_raw[i]),
         .level_o (btn_level[i])
      );
   end

   // Press edges only; releases are not reported.
   assign rise = btn_level & ~level_dly_q;

   // Move FSM next state; a start press overrides everything and aborts a pending move.
   always_comb begin
      state_d    = state_q;
      move_req_d = move_req_q;
      move_dir_d = move_dir_q;
      case (state_q)
         IDLE: begin
            if (|rise[BTN_RIGHT:BTN_UP]) begin
               move_dir_d = prio_dir(rise[BTN_RIGHT:BTN_UP]);
               move_req_d = 1'b1;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (move_ack) begin
               move_req_d = 1'b0;
               state_d    = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (btn_level[BTN_RIGHT:BTN_UP] == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            move_req_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
      if (rise[BTN_START]) begin
         move_req_d = 1'b0;
         state_d    = IDLE;
      end
   end

   // Edge-detect delay, start pulse and FSM registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_dly_q   <= '0;
         start_pulse_q <= 1'b0;
         state_q       <= IDLE;
         move_req_q    <= 1'b0;
         move_dir_q    <= DIR_UP;
      end else begin
         level_dly_q   <= btn_level;
         start_pulse_q <= rise[BTN_START];
         state_q       <= state_d;
         move_req_q    <= move_req_d;
         move_dir_q    <= move_dir_d;
      end
   end

   assign start_pulse = start_pulse_q;
   assign move_req    = move_req_q;
   assign move_dir    = move_dir_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a short debounce window.
module tb_btn_conditioner;
   import btn_pkg::*;

   logic       clk;
   logic       rst;
   logic [4:0] btn_raw;
   logic       move_ack;
   logic [4:0] btn_level;
   logic       start_pulse;
   logic       move_req;
   logic [1:0] move_dir;

   int checks = 0;
   int errors = 0;

   btn_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .move_ack    (move_ack),
      .btn_level   (btn_level),
      .start_pulse (start_pulse),
      .move_req    (move_req),
      .move_dir    (move_dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n clock edges, landing 1 time unit after the last edge.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [4:0] lvl, input logic sp,
                           input logic req, input logic [1:0] dir);
      chk({tag, ".level"}, 8'(btn_level), 8'(lvl));
      chk({tag, ".start"}, 8'(start_pulse), 8'(sp));
      chk({tag, ".req"},   8'(move_req), 8'(req));
      chk({tag, ".dir"},   8'(move_dir), 8'(dir));
   endtask

   task automatic chk_state(input string tag, input move_state_e exp);
      chk(tag, 8'(dut.state_q), 8'(exp));
   endtask

   initial begin
      rst      = 1'b1;
      btn_raw  = 5'b0;
      move_ack = 1'b0;
      #3;
      chk_outs("reset_async", 5'b0, 1'b0, 1'b0, 2'b00);
      tick(2);
      rst = 1'b0;
      chk_outs("reset", 5'b0, 1'b0, 1'b0, 2'b00);
      chk_state("reset.state", IDLE);

      // Clean press of up
      btn_raw[1] = 1'b1;
      tick(5);
      chk("press.level_c5", 8'(btn_level), 8'h00);
      tick(1);
      chk_outs("press.c6", 5'b00010, 1'b0, 1'b0, 2'b00);
      tick(1);
      chk_outs("press.c7", 5'b00010, 1'b0, 1'b1, DIR_UP);
      chk_state("press.state_req", REQ);
      tick(3);
      chk("press.req_c10", 8'(move_req), 8'h01);
      move_ack = 1'b1;
      tick(1);
      move_ack = 1'b0;
      chk("press.req_c11", 8'(move_req), 8'h00);
      chk_state("press.wait_rel", WAIT_REL);
      btn_raw[1] = 1'b0;
      tick(5);
      chk_state("release.still_wait", WAIT_REL);
      tick(1);
      chk("release.level", 8'(btn_level), 8'h00);
      tick(1);
      chk_state("release.idle", IDLE);
      tick(3);
      chk("release.no_second", 8'(move_req), 8'h00);

      // Bounce on right: 3 high, 1 low, 3 high, then low
      btn_raw[4] = 1'b1; tick(3);
      btn_raw[4] = 1'b0; tick(1);
      btn_raw[4] = 1'b1; tick(3);
      chk("bounce.level_mid", 8'(btn_level), 8'h00);
      btn_raw[4] = 1'b0; tick(6);
      chk("bounce.level", 8'(btn_level), 8'h00);
      chk("bounce.req", 8'(move_req), 8'h00);
      btn_raw[4] = 1'b1;
      tick(6);
      chk("hold.level", 8'(btn_level), 8'h10);
      tick(1);
      chk_outs("hold.move", 5'b10000, 1'b0, 1'b1, DIR_RIGHT);
      move_ack = 1'b1;
      tick(1);
      move_ack = 1'b0;
      btn_raw[4] = 1'b0;
      tick(7);
      chk_state("hold.idle", IDLE);

      // Chord: left and down together, down wins
      btn_raw[3] = 1'b1;
      btn_raw[2] = 1'b1;
      tick(6);
      chk("chord.level", 8'(btn_level), 8'h0C);
      tick(1);
      chk_outs("chord.move", 5'b01100, 1'b0, 1'b1, DIR_DOWN);
      move_ack = 1'b1;
      tick(1);
      move_ack = 1'b0;
      chk("chord.acked", 8'(move_req), 8'h00);
      tick(5);
      chk("chord.single", 8'(move_req), 8'h00);
      chk_state("chord.wait_rel", WAIT_REL);
      btn_raw[3] = 1'b0;
      btn_raw[2] = 1'b0;
      tick(7);
      chk_state("chord.idle", IDLE);

      // No ack: later presses of right do not disturb pending down
      btn_raw[2] = 1'b1;
      tick(7);
      chk_outs("noack.move", 5'b00100, 1'b0, 1'b1, DIR_DOWN);
      btn_raw[4] = 1'b1;
      tick(7);
      chk_outs("noack.right_held", 5'b10100, 1'b0, 1'b1, DIR_DOWN);
      btn_raw[4] = 1'b0;
      tick(7);
      chk_outs("noack.right_rel", 5'b00100, 1'b0, 1'b1, DIR_DOWN);

      // Start aborts the pending move
      btn_raw[0] = 1'b1;
      tick(6);
      chk_outs("start.level", 5'b00101, 1'b0, 1'b1, DIR_DOWN);
      tick(1);
      chk("start.pulse", 8'(start_pulse), 8'h01);
      chk("start.abort", 8'(move_req), 8'h00);
      chk_state("start.idle", IDLE);
      tick(1);
      chk("start.one_cycle", 8'(start_pulse), 8'h00);
      tick(3);
      chk("start.held_no_move", 8'(move_req), 8'h00);
      btn_raw = 5'b0;
      tick(7);

      // Start and up rise together: start wins
      btn_raw[0] = 1'b1;
      btn_raw[1] = 1'b1;
      tick(7);
      chk("tie.pulse", 8'(start_pulse), 8'h01);
      chk("tie.req", 8'(move_req), 8'h00);
      tick(1);
      chk("tie.pulse_off", 8'(start_pulse), 8'h00);
      chk("tie.req_later", 8'(move_req), 8'h00);
      btn_raw = 5'b0;
      tick(7);

      // Async reset while a left move is pending
      btn_raw[3] = 1'b1;
      tick(7);
      chk_outs("arst.pre", 5'b01000, 1'b0, 1'b1, DIR_LEFT);
      #2;
      rst = 1'b1;
      #1;
      chk_outs("arst.immediate", 5'b00000, 1'b0, 1'b0, 2'b00);
      tick(1);
      rst = 1'b0;
      tick(6);
      chk_outs("arst.relevel", 5'b01000, 1'b0, 1'b0, 2'b00);
      tick(1);
      chk_outs("arst.remove", 5'b01000, 1'b0, 1'b1, DIR_LEFT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Sits between the five raw board buttons and the game-logic block.
- Synchronises and debounces each button, then turns the debounced levels into clean one-shot commands: a single-cycle start pulse and a one-move-per-press direction request with a req/ack handshake.
- Guarantees that the game logic sees exactly one move per physical press, never a held-level repeat.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised input must differ from its stable value before the stable value flips (10 ms at 100 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock (100 MHz domain, same clock as the game logic)
- rst  in  1  asynchronous, active-high reset
- btn_raw  in  5  raw buttons: [0] start/reset, [1] up, [2] down, [3] left, [4] right
- move_ack  in  1  game logic accepts the pending move (sampled only in REQ)
- btn_level  out  5  debounced button levels
- start_pulse  out  1  one-cycle pulse on debounced rising edge of btn[0]
- move_req  out  1  a move is pending
- move_dir  out  2  00 up, 01 down, 10 left, 11 right; valid while move_req=1

Behaviour:
- Reset (async, rst=1): all registers 0, including synchroniser flops, debounce counters and stable levels. Outputs on reset: btn_level=0, start_pulse=0, move_req=0, move_dir=00. FSM state is IDLE.
- Synchroniser: each btn_raw bit passes through a 2-flop synchroniser (sync).
- Debounce, per bit:
  - sync==stable: counter is 0.
  - sync!=stable and counter<DEBOUNCE_CYCLES-1: counter increments.
  - sync!=stable and counter==DEBOUNCE_CYCLES-1: stable<=sync and counter<=0.
  - A glitch shorter than DEBOUNCE_CYCLES resets the counter and the stable value never flips.
  - btn_level = stable.
- Edge detect: rise[i] = stable[i] & ~stable_d[i], where stable_d is stable delayed one cycle. Release edges are not reported.
- Latency from a raw change to btn_level is 2 synchroniser cycles + DEBOUNCE_CYCLES cycles. start_pulse and move_req assert at the clock edge after btn_level rises.
- start_pulse: registered version of rise[0]. It is exactly 1 cycle high per debounced press.
- Move FSM states: IDLE, REQ, WAIT_REL.
  - IDLE:
    - If any rise[4:1]: latch move_dir from the highest-priority rising bit, set move_req=1, go to REQ.
    - Priority when several rise in the same cycle: up > down > left > right.
    - A button already held when entering IDLE does not generate a move; only a rising edge does.
    - move_ack is ignored in IDLE.
  - REQ:
    - move_req and move_dir are held constant.
    - If move_ack=1: move_req<=0 and go to WAIT_REL. Ack in the same cycle as the req-rise edge counts on the next sampled cycle only, because REQ is entered at that edge.
    - New direction edges are dropped.
  - WAIT_REL:
    - Stay until btn_level[4:1]==0, then go to IDLE.
    - Edges in this state are dropped.
    - Result: one move per press, and a chord yields one move.
- Start handling:
  - rise[0] in any state forces the FSM to IDLE and sets move_req<=0 on the same edge start_pulse asserts. This aborts a pending move.
  - If rise[0] and a direction rise occur in the same cycle, start wins and no move is generated.
- Reset mid-debounce discards partial counts. After rst is released, a button already held produces a press only after the full sync + DEBOUNCE_CYCLES latency, because stable restarts at 0.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

Decomposition:
- Shared package btn_pkg holds:
  - DIR_UP=2'b00, DIR_DOWN=2'b01, DIR_LEFT=2'b10, DIR_RIGHT=2'b11
  - button index constants BTN_START=0 … BTN_RIGHT=4
  - FSM state encoding IDLE/REQ/WAIT_REL
- One sub-module: debounce_bit (2-flop sync + counter + stable level, parameter DEBOUNCE_CYCLES), instantiated 5 times.
- The edge-detect and move FSM stay in btn_conditioner.

Test Plan (all with DEBOUNCE_CYCLES=4):
- Clean press: raise btn_raw[1] at cycle 0 and hold → btn_level[1]=1 at cycle 6; move_req=1 and move_dir=00 at cycle 7. Assert move_ack at cycle 10 → move_req=0 at cycle 11, FSM in WAIT_REL. Release the button → FSM back in IDLE; no second move.
- Bounce: toggle btn_raw[4] high 3 cycles, low 1, high 3 → btn_level stays 0 and no move_req. Then hold high → move_dir=11 after the full latency.
- Chord priority: raise btn_raw[3] and btn_raw[2] the same cycle → a single move_req with move_dir=01. After ack, only one move has occurred while both are held.
- No ack, repeated presses: press down and never ack; press right and release → move_req stays 1 with move_dir=01 throughout.
- Start abort: with move_req=1 pending, press btn_raw[0] → start_pulse high for exactly 1 cycle, and move_req=0 on that same edge.
- Async reset mid-REQ: assert rst between clock edges while move_req=1 → move_req, btn_level and start_pulse go to 0 immediately without waiting for clk. After rst is released with a button held, the next move appears 7 cycles later.
